// File: rtl/mountaincar_pkg.sv
// Shared constants and types for MountainCar environment sequencers.
// Floats are handled purely as IEEE-754 single-precision bit patterns.
package mountaincar_pkg;

  localparam logic [31:0] GOAL_POS = 32'h3F000000;
  localparam logic [31:0] MIN_POS  = 32'hBF99999A;
  localparam logic [31:0] FZERO    = 32'h00000000;
  localparam logic [31:0] NZERO    = 32'h80000000;

  localparam logic [1:0] ACT_LEFT  = 2'd0;
  localparam logic [1:0] ACT_NONE  = 2'd1;
  localparam logic [1:0] ACT_RIGHT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READY,
    S_VEL_REQ,
    S_VEL_WAIT,
    S_POS_REQ,
    S_POS_WAIT,
    S_FIXUP,
    S_OBS,
    S_ERR
  } state_t;

endpackage

// File: rtl/mountaincar_term_check.sv
// Combinational end-of-step rules: left-wall velocity clamp, goal and truncation.
// Bit-level float compares; valid because only non-negative magnitudes are ordered.
module mountaincar_term_check
  import mountaincar_pkg::*;
#(
  parameter int POS_WL    = 32,
  parameter int VEL_WL    = 32,
  parameter int CNT_WL    = 16,
  parameter int MAX_STEPS = 200
) (
  input  logic [POS_WL-1:0] pos,
  input  logic [VEL_WL-1:0] vel,
  input  logic [CNT_WL-1:0] step_cnt,
  output logic [VEL_WL-1:0] vel_fix,
  output logic              done,
  output logic              trunc
);

  logic at_wall;
  logic vel_neg;
  logic pos_goal;
  logic vel_fix_nonneg;

  // -0.0 is not a leftward velocity, so it survives the wall clamp untouched
  assign at_wall        = (pos == POS_WL'(MIN_POS));
  assign vel_neg        = vel[VEL_WL-1] && (vel != VEL_WL'(NZERO));
  assign vel_fix        = (at_wall && vel_neg) ? VEL_WL'(FZERO) : vel;

  assign pos_goal       = !pos[POS_WL-1] && (pos >= POS_WL'(GOAL_POS));
  assign vel_fix_nonneg = !vel_fix[VEL_WL-1] || (vel_fix == VEL_WL'(NZERO));
  assign done           = pos_goal && vel_fix_nonneg;
  assign trunc          = (step_cnt == CNT_WL'(MAX_STEPS)) && !done;

endmodule

// File: rtl/mountaincar_step_ctrl.sv
// MountainCar episode/step sequencer: owns (pos, vel), drives the velocity and
// position engines for each accepted action and returns an observation.
module mountaincar_step_ctrl
  import mountaincar_pkg::*;
#(
  parameter int VEL_WL    = 32,
  parameter int POS_WL    = 32,
  parameter int ACT_WL    = 2,
  parameter int MAX_STEPS = 200,
  parameter int CNT_WL    = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_reset_req,
  input  logic [POS_WL-1:0] i_init_pos,
  input  logic              i_act_valid,
  input  logic [ACT_WL-1:0] i_act,
  output logic              o_act_ready,
  output logic              o_obs_valid,
  input  logic              i_obs_ready,
  output logic [POS_WL-1:0] o_pos,
  output logic [VEL_WL-1:0] o_vel,
  output logic              o_done,
  output logic              o_trunc,
  output logic [CNT_WL-1:0] o_step_cnt,
  output logic              o_err,
  output logic              o_ve_ena,
  output logic [VEL_WL-1:0] o_ve_vel,
  output logic [POS_WL-1:0] o_ve_pos,
  output logic [ACT_WL-1:0] o_ve_act,
  input  logic              i_ve_valid,
  input  logic [VEL_WL-1:0] i_ve_vel,
  output logic              o_pe_ena,
  output logic [POS_WL-1:0] o_pe_pos,
  output logic [VEL_WL-1:0] o_pe_vel,
  input  logic              i_pe_valid,
  input  logic [POS_WL-1:0] i_pe_pos
);

  // state      | meaning
  // IDLE       | after reset, waiting for the first episode start
  // READY      | offering o_act_ready unless the episode has ended
  // VEL_REQ    | one-cycle velocity engine start
  // VEL_WAIT   | waiting for velocity result, timeout armed
  // POS_REQ    | one-cycle position engine start
  // POS_WAIT   | waiting for position result, timeout armed
  // FIXUP      | apply wall / goal / truncation rules
  // OBS        | observation offered to the agent
  // ERR        | engine timed out; only an episode reset leaves

  localparam int TMR_WL = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [POS_WL-1:0]   pos_q;
  logic [VEL_WL-1:0]   vel_q;
  logic [ACT_WL-1:0]   act_q;
  logic [CNT_WL-1:0]   step_cnt_q;
  logic [TMR_WL-1:0]   tmr;
  logic                done_q;
  logic                trunc_q;
  logic                err_q;
  logic                ve_ena_q;
  logic                pe_ena_q;
  logic                act_ready_q;
  logic                obs_valid_q;

  logic [VEL_WL-1:0]   fix_vel;
  logic                fix_done;
  logic                fix_trunc;
  logic                reset_ok;

  mountaincar_term_check #(
    .POS_WL   (POS_WL),
    .VEL_WL   (VEL_WL),
    .CNT_WL   (CNT_WL),
    .MAX_STEPS(MAX_STEPS)
  ) u_term_check (
    .pos     (pos_q),
    .vel     (vel_q),
    .step_cnt(step_cnt_q),
    .vel_fix (fix_vel),
    .done    (fix_done),
    .trunc   (fix_trunc)
  );

  assign reset_ok = i_reset_req &&
                    ((state == S_IDLE) || (state == S_READY) ||
                     (state == S_OBS)  || (state == S_ERR));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      pos_q       <= '0;
      vel_q       <= '0;
      act_q       <= '0;
      step_cnt_q  <= '0;
      tmr         <= '0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
      err_q       <= 1'b0;
      ve_ena_q    <= 1'b0;
      pe_ena_q    <= 1'b0;
      act_ready_q <= 1'b0;
      obs_valid_q <= 1'b0;
    end else begin
      ve_ena_q <= 1'b0;
      pe_ena_q <= 1'b0;
      if (reset_ok) begin
        pos_q       <= i_init_pos;
        vel_q       <= '0;
        step_cnt_q  <= '0;
        done_q      <= 1'b0;
        trunc_q     <= 1'b0;
        err_q       <= 1'b0;
        act_ready_q <= 1'b0;
        obs_valid_q <= 1'b1;
        state       <= S_OBS;
      end else begin
        case (state)
          S_READY: begin
            if (act_ready_q && i_act_valid) begin
              act_q       <= i_act;
              if (step_cnt_q != '1) step_cnt_q <= step_cnt_q + 1'b1;
              act_ready_q <= 1'b0;
              ve_ena_q    <= 1'b1;
              state       <= S_VEL_REQ;
            end
          end
          S_VEL_REQ: begin
            tmr   <= TMR_WL'(TIMEOUT - 1);
            state <= S_VEL_WAIT;
          end
          S_VEL_WAIT: begin
            if (i_ve_valid) begin
              vel_q    <= i_ve_vel;
              pe_ena_q <= 1'b1;
              state    <= S_POS_REQ;
            end else if (tmr == '0) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_POS_REQ: begin
            tmr   <= TMR_WL'(TIMEOUT - 1);
            state <= S_POS_WAIT;
          end
          S_POS_WAIT: begin
            if (i_pe_valid) begin
              pos_q <= i_pe_pos;
              state <= S_FIXUP;
            end else if (tmr == '0) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_FIXUP: begin
            vel_q       <= fix_vel;
            done_q      <= fix_done;
            trunc_q     <= fix_trunc;
            obs_valid_q <= 1'b1;
            state       <= S_OBS;
          end
          S_OBS: begin
            if (i_obs_ready) begin
              obs_valid_q <= 1'b0;
              act_ready_q <= !done_q && !trunc_q;
              state       <= S_READY;
            end
          end
          S_IDLE, S_ERR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_act_ready = act_ready_q;
  assign o_obs_valid = obs_valid_q;
  assign o_pos       = pos_q;
  assign o_vel       = vel_q;
  assign o_done      = done_q;
  assign o_trunc     = trunc_q;
  assign o_step_cnt  = step_cnt_q;
  assign o_err       = err_q;
  assign o_ve_ena    = ve_ena_q;
  assign o_ve_vel    = vel_q;
  assign o_ve_pos    = pos_q;
  assign o_ve_act    = act_q;
  assign o_pe_ena    = pe_ena_q;
  assign o_pe_pos    = pos_q;
  assign o_pe_vel    = vel_q;

endmodule

// File: doc/mountaincar_step_ctrl.md
Name: mountaincar_step_ctrl

Overview:
Episode/step sequencer for the MountainCar environment; it is the requester side of the velocity and position compute engines.
- Holds the authoritative (pos, vel) state as IEEE-754 single-precision values.
- Accepts actions from the agent over a valid/ready handshake.
- For each action: issues a velocity-engine request, then a position-engine request, applies the left-wall and termination rules, and returns an observation over a second valid/ready handshake.

Parameters:
VEL_WL, 32, velocity word width (float32)
POS_WL, 32, position word width (float32)
ACT_WL, 2, action width (0 = left, 1 = none, 2 = right)
MAX_STEPS, 200, truncation step limit
CNT_WL, 16, step counter width
TIMEOUT, 64, max cycles waiting on an engine result

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_reset_req  in  1  start new episode (level)
i_init_pos  in  POS_WL  initial position for new episode
i_act_valid  in  1  action offered
i_act  in  ACT_WL  action
o_act_ready  out  1  action accepted when valid&ready
o_obs_valid  out  1  observation offered
i_obs_ready  in  1  observation consumed when valid&ready
o_pos  out  POS_WL  state position
o_vel  out  VEL_WL  state velocity
o_done  out  1  goal reached
o_trunc  out  1  step limit reached
o_step_cnt  out  CNT_WL  steps in current episode
o_err  out  1  engine timeout, sticky
o_ve_ena  out  1  velocity engine start pulse
o_ve_vel, o_ve_pos  out  VEL_WL/POS_WL  velocity engine operands
o_ve_act  out  ACT_WL  velocity engine action
i_ve_valid  in  1  velocity result valid
i_ve_vel  in  VEL_WL  new velocity, clipped to ±0.07
o_pe_ena  out  1  position engine start pulse
o_pe_pos, o_pe_vel  out  POS_WL/VEL_WL  position engine operands
i_pe_valid  in  1  position result valid
i_pe_pos  in  POS_WL  new position, clipped to [-1.2, 0.6]

Behaviour:
- Reset (i_rst_n=0, async): state IDLE. All outputs 0: pos, vel, step_cnt, done, trunc, err, ena pulses, ready, obs_valid.
- States: IDLE, READY, VEL_REQ, VEL_WAIT, POS_REQ, POS_WAIT, FIXUP, OBS, ERR.
- i_reset_req is sampled only in IDLE, READY, OBS and ERR; in any other state it is ignored (it is a level, so the agent holds it).
  - On acceptance: pos=i_init_pos, vel=0x00000000, step_cnt=0, done=0, trunc=0, err=0, next state OBS.
  - Reset takes priority over an action or obs handshake in the same cycle.
- READY:
  - o_act_ready=1 only when !done && !trunc; while done or trunc is set, only i_reset_req leaves READY.
  - On accept: latch act, step_cnt+1 (saturating), next state VEL_REQ.
- VEL_REQ: o_ve_ena=1 for exactly one cycle; operands are the registered vel/pos/act, held stable until VEL_WAIT exits. Next state VEL_WAIT.
- VEL_WAIT: on i_ve_valid, vel=i_ve_vel, next state POS_REQ.
- POS_REQ: o_pe_ena=1 for exactly one cycle; o_pe_pos=pos, o_pe_vel=new vel. Next state POS_WAIT.
- POS_WAIT: on i_pe_valid, pos=i_pe_pos, next state FIXUP.
- Valid pulses arriving outside the matching WAIT state are ignored.
- Timeout counter clears on entry to each WAIT state. Reaching TIMEOUT cycles -> ERR; o_err=1 (sticky); state registers keep their last values.
- FIXUP (one cycle):
  - Left wall: if pos==0xBF99999A (-1.2) and vel sign=1 and vel!=0x80000000, then vel=0x00000000.
  - Done: done = (pos sign=0 and pos ≥u 0x3F000000 (0.5)) and (vel sign=0 or vel==0x80000000).
  - Trunc: trunc = (step_cnt==MAX_STEPS) and !done.
  - Next state OBS.
- OBS:
  - o_obs_valid=1; o_pos/o_vel/o_done/o_trunc/o_step_cnt are stable while valid.
  - On i_obs_ready: next state READY.
- Float compares are bit-level only: for non-negative operands, an unsigned compare equals a float compare. No NaN handling; engines never produce NaN.
- Latency from action accept to o_obs_valid = 4 + engine latencies.
- ERR: only i_reset_req exits. A stale engine result arriving after exit is ignored by the WAIT-state rule above.

Decomposition:
- Shared mountaincar_pkg: float constants GOAL_POS 0x3F000000, MIN_POS 0xBF99999A, FZERO 0x00000000, NZERO 0x80000000; state encodings; action codes.
- One sub-module: mountaincar_term_check (combinational FIXUP rules: left wall, done, trunc), so it is reusable by other environment sequencers.

Test Plan:
- Reset episode with init_pos 0xBF000000 (-0.5) -> OBS with pos=0xBF000000, vel=0, step_cnt=0, done=0; obs_valid held until ready.
- Action 2 with a model engine (latency 5, returns vel 0x3A83126F, pos 0xBEFFBE77) -> o_ve_ena is a one-cycle pulse, o_pe_vel=0x3A83126F, obs step_cnt=1, done=0.
- Position engine returns 0xBF99999A with velocity 0xBD8F5C29 -> obs vel=0x00000000, pos=0xBF99999A.
- Position engine returns 0x3F000000 with vel 0x3A83126F -> done=1, o_act_ready stays 0 until reset_req.
- MAX_STEPS=3, three actions without reaching goal -> third obs has trunc=1, step_cnt=3.
- Velocity engine silent -> o_err=1 after TIMEOUT cycles in VEL_WAIT; reset_req clears it; async i_rst_n drop mid-VEL_WAIT zeroes all outputs immediately.
